// File: rtl/fetch_pfq.sv
// Instruction prefetch queue for a mixed RV32/RV16 front end.
// A fixed-latency SRAM fills a circular buffer of 64-bit words. The head
// words are then cut into 16- or 32-bit instructions for decode, and an
// instruction may straddle two words. A redirect flushes everything and
// restarts fetching at a new PC. A misaligned target parks the fetcher
// until the next good redirect.
module fetch_pfq #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                      clk,
  input  logic                      cpurst,
  input  logic [PC_W-1:0]           boot_addr,
  input  logic                      redirect,
  input  logic [PC_W-1:0]           redirect_pc,
  output logic                      isram_cs,
  output logic [PC_W-4:0]           isram_adr,
  input  logic [63:0]               instr_fromsram,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [31:0]               rv32_instr_todec,
  output logic [PC_W-1:0]           fetch_pc,
  output logic                      fe2de_rv16,
  output logic                      fetch_misalign,
  output logic [$clog2(DEPTH):0]    pfq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [63:0]      mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             inflight_r;
  logic [PC_W-4:0]  req_adr_r;
  logic [PC_W-1:0]  pc_r;
  logic             misalign_r;

  logic [63:0]      head_s;
  logic [15:0]      nxt_lo_s;
  logic [1:0]       hw_s;
  logic [15:0]      lo_half_s;
  logic [31:0]      instr32_s;
  logic             rv16_s;
  logic             straddle_s;
  logic             present_s;
  logic             last_half_s;
  logic             xfer_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [AW-1:0]    nxt_ptr_s;
  logic [CW:0]      occupancy_s;

  assign nxt_ptr_s = rd_ptr_r + AW'(1);
  assign head_s    = mem_r[rd_ptr_r];
  assign nxt_lo_s  = mem_r[nxt_ptr_s][15:0];
  assign hw_s      = pc_r[2:1];

  // Slice the current halfword and the candidate 32-bit instruction out of the head word(s)
  always_comb begin
    lo_half_s = 16'h0000;
    instr32_s = 32'h0000_0000;
    case (hw_s)
      2'd0: begin
        lo_half_s = head_s[15:0];
        instr32_s = head_s[31:0];
      end
      2'd1: begin
        lo_half_s = head_s[31:16];
        instr32_s = head_s[47:16];
      end
      2'd2: begin
        lo_half_s = head_s[47:32];
        instr32_s = head_s[63:32];
      end
      2'd3: begin
        lo_half_s = head_s[63:48];
        instr32_s = {nxt_lo_s, head_s[63:48]};
      end
      default: begin
        lo_half_s = 16'h0000;
        instr32_s = 32'h0000_0000;
      end
    endcase
  end

  assign rv16_s      = (lo_half_s[1:0] != 2'b11);
  assign straddle_s  = !rv16_s && (hw_s == 2'd3);
  // A straddling RV32 needs the following word to be present as well.
  assign present_s   = straddle_s ? (count_r >= CW'(2)) : (count_r != CW'(0));
  // The head word is exhausted once its top halfword has been consumed.
  assign last_half_s = rv16_s ? (hw_s == 2'd3) : (hw_s >= 2'd2);

  assign dec_valid        = present_s && !misalign_r && !cpurst;
  assign rv32_instr_todec = rv16_s ? {16'h0000, lo_half_s} : instr32_s;
  assign fetch_pc         = pc_r;
  assign fe2de_rv16       = rv16_s;
  assign fetch_misalign   = misalign_r && !cpurst;
  assign pfq_count        = cpurst ? CW'(0) : count_r;
  assign isram_adr        = req_adr_r;

  // A redirect discards any transfer in the same cycle.
  assign xfer_s = dec_valid && dec_ready && !redirect;
  assign pop_s  = xfer_s && last_half_s;
  // A response that meets a redirect belongs to the old stream and is dropped.
  assign drop_s = inflight_r && redirect;
  assign push_s = inflight_r && !drop_s && !cpurst;

  // Outstanding responses count against capacity so a push can never overflow.
  assign occupancy_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
  assign isram_cs    = (occupancy_s < DEPTH_L) && !redirect && !cpurst && !misalign_r;

  // Queue storage: the returned SRAM word lands at the write pointer
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= instr_fromsram;
    end
  end

  // Pointers, occupancy, request address, PC and misalign state
  always_ff @(posedge clk) begin
    if (cpurst) begin
      rd_ptr_r   <= AW'(0);
      wr_ptr_r   <= AW'(0);
      count_r    <= CW'(0);
      inflight_r <= 1'b0;
      misalign_r <= 1'b0;
      pc_r       <= boot_addr;
      req_adr_r  <= boot_addr[PC_W-1:3];
    end else if (redirect) begin
      rd_ptr_r   <= AW'(0);
      wr_ptr_r   <= AW'(0);
      count_r    <= CW'(0);
      inflight_r <= 1'b0;
      misalign_r <= redirect_pc[0];
      pc_r       <= redirect_pc;
      req_adr_r  <= redirect_pc[PC_W-1:3];
    end else begin
      inflight_r <= isram_cs;
      if (isram_cs) begin
        req_adr_r <= req_adr_r + (PC_W-3)'(1);
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (xfer_s) begin
        pc_r <= pc_r + (rv16_s ? PC_W'(2) : PC_W'(4));
      end
    end
  end

endmodule

// File: tb/tb_fetch_pfq.sv
// Directed bench for fetch_pfq with a scoreboard. Each phase queues the
// instructions it expects decode to receive. An independent monitor pops
// and compares on every accepted transfer.
module tb_fetch_pfq;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic              clk = 1'b0;
  logic              cpurst;
  logic [PC_W-1:0]   boot_addr;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              isram_cs;
  logic [PC_W-4:0]   isram_adr;
  logic [63:0]       instr_fromsram;
  logic              dec_valid;
  logic              dec_ready;
  logic [31:0]       rv32_instr_todec;
  logic [PC_W-1:0]   fetch_pc;
  logic              fe2de_rv16;
  logic              fetch_misalign;
  logic [$clog2(DEPTH):0] pfq_count;

  fetch_pfq #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk              (clk),
    .cpurst           (cpurst),
    .boot_addr        (boot_addr),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .isram_cs         (isram_cs),
    .isram_adr        (isram_adr),
    .instr_fromsram   (instr_fromsram),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .rv32_instr_todec (rv32_instr_todec),
    .fetch_pc         (fetch_pc),
    .fe2de_rv16       (fe2de_rv16),
    .fetch_misalign   (fetch_misalign),
    .pfq_count        (pfq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rv16;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   max_cnt = 0;

  logic [63:0] sram [logic [28:0]];

  function automatic logic [63:0] sram_rd(input logic [28:0] a);
    if (sram.exists(a)) return sram[a];
    else return 64'h00000013_00000013;
  endfunction

  function automatic logic [31:0] ins(input int k);
    logic [11:0] imm;
    imm = 12'(k);
    return {imm, 20'h00013};
  endfunction

  // One-cycle SRAM read latency
  always @(posedge clk) begin
    if (isram_cs) instr_fromsram <= sram_rd(isram_adr);
  end

  // Scoreboard monitor: compare every accepted instruction with the expected stream
  always @(negedge clk) begin
    if (int'(pfq_count) > max_cnt) max_cnt = int'(pfq_count);
    if (!cpurst && !redirect && dec_valid && dec_ready && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (fetch_pc !== e.pc || rv32_instr_todec !== e.instr || fe2de_rv16 !== e.rv16) begin
        errors++;
        $display("FAIL xfer: got pc=%h instr=%h rv16=%b, want pc=%h instr=%h rv16=%b",
                 fetch_pc, rv32_instr_todec, fe2de_rv16, e.pc, e.instr, e.rv16);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic rv16);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.rv16 = rv16;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d instructions never delivered, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_boot_stream(input int n);
    for (int k = 0; k < n; k++) push_exp(32'h8000_0000 + 32'(4 * k), ins(k), 1'b0);
  endtask

  initial begin
    int run;
    for (int i = 0; i < 8; i++) sram[29'h1000_0000 + 29'(i)] = {ins(2 * i + 1), ins(2 * i)};
    sram[29'h200] = 64'h0013_00A0_0093_4501;
    sram[29'h201] = 64'h0001_0020_0093_0000;
    sram[29'h400] = 64'h02A0_0513_0000_0013;
    sram[29'h401] = 64'h0001_00B0_0593_4585;
    sram[29'h600] = 64'h0030_0093_0020_0093;

    cpurst = 1'b1;
    boot_addr = 32'h8000_0000;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    dec_ready = 1'b1;
    instr_fromsram = 64'h0;

    // Reset state and boot
    step();
    step();
    sample();
    chk("rst_cs", 64'(isram_cs), 64'h0);
    chk("rst_valid", 64'(dec_valid), 64'h0);
    chk("rst_count", 64'(pfq_count), 64'h0);
    chk("rst_misalign", 64'(fetch_misalign), 64'h0);
    step();
    cpurst = 1'b0;
    push_boot_stream(16);
    sample();
    chk("boot_pc", 64'(fetch_pc), 64'h8000_0000);
    chk("boot_cs", 64'(isram_cs), 64'h1);
    chk("boot_adr", 64'(isram_adr), 64'h1000_0000);
    run = 0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (dec_valid) run++;
      else if (run > 0) break;
      if (run == 16) break;
    end
    chk("stream_back_to_back", 64'(run), 64'd16);
    drain("stream");

    // Compressed, aligned RV32 and straddling RV32 from one word
    step();
    redirect = 1'b1;
    redirect_pc = 32'h1000;
    dec_ready = 1'b0;
    push_exp(32'h1000, 32'h0000_4501, 1'b1);
    push_exp(32'h1002, 32'h00A0_0093, 1'b0);
    push_exp(32'h1006, 32'h0000_0013, 1'b0);
    push_exp(32'h100A, 32'h0020_0093, 1'b0);
    push_exp(32'h100E, 32'h0000_0001, 1'b1);
    step();
    redirect = 1'b0;
    sample();
    chk("rd1000_cs", 64'(isram_cs), 64'h1);
    chk("rd1000_adr", 64'(isram_adr), 64'h200);
    chk("rd1000_pc", 64'(fetch_pc), 64'h1000);
    step();
    sample();
    chk("rd1000_valid_early", 64'(dec_valid), 64'h0);
    step();
    sample();
    chk("rd1000_valid_2cyc", 64'(dec_valid), 64'h1);
    chk("rd1000_instr", 64'(rv32_instr_todec), 64'h4501);
    step();
    dec_ready = 1'b1;
    drain("mixed");

    // Straddling first instruction waits for the second word
    step();
    redirect = 1'b1;
    redirect_pc = 32'h1006;
    dec_ready = 1'b0;
    push_exp(32'h1006, 32'h0000_0013, 1'b0);
    push_exp(32'h100A, 32'h0020_0093, 1'b0);
    push_exp(32'h100E, 32'h0000_0001, 1'b1);
    step();
    redirect = 1'b0;
    step();
    step();
    sample();
    chk("strad_count1", 64'(pfq_count), 64'h1);
    chk("strad_valid_wait", 64'(dec_valid), 64'h0);
    step();
    sample();
    chk("strad_valid_3cyc", 64'(dec_valid), 64'h1);
    chk("strad_instr", 64'(rv32_instr_todec), 64'h0000_0013);
    step();
    dec_ready = 1'b1;
    drain("straddle");

    // Decode stall: queue saturates and outputs hold
    step();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0000;
    dec_ready = 1'b0;
    push_boot_stream(16);
    step();
    redirect = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      step();
      sample();
      if (c >= 3) begin
        chk("stall_pc", 64'(fetch_pc), 64'h8000_0000);
        chk("stall_instr", 64'(rv32_instr_todec), 64'(ins(0)));
      end
    end
    chk("stall_count_full", 64'(pfq_count), 64'(DEPTH));
    chk("stall_cs_off", 64'(isram_cs), 64'h0);
    chk("stall_valid", 64'(dec_valid), 64'h1);
    step();
    dec_ready = 1'b1;
    drain("stall_release");
    chk("max_count", 64'(max_cnt), 64'(DEPTH));

    // Redirect while a response returns and a transfer is offered
    step();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0000;
    step();
    redirect = 1'b0;
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h2004;
    push_exp(32'h2004, 32'h02A0_0513, 1'b0);
    push_exp(32'h2008, 32'h0000_4585, 1'b1);
    push_exp(32'h200A, 32'h00B0_0593, 1'b0);
    push_exp(32'h200E, 32'h0000_0001, 1'b1);
    sample();
    chk("drop_setup_valid", 64'(dec_valid), 64'h1);
    step();
    redirect = 1'b0;
    sample();
    chk("drop_pc", 64'(fetch_pc), 64'h2004);
    chk("drop_count", 64'(pfq_count), 64'h0);
    chk("drop_valid", 64'(dec_valid), 64'h0);
    chk("drop_cs", 64'(isram_cs), 64'h1);
    chk("drop_adr", 64'(isram_adr), 64'h400);
    step();
    sample();
    chk("drop_count_next", 64'(pfq_count), 64'h0);
    drain("drop");

    // Misaligned redirect parks the fetcher until a good redirect
    step();
    redirect = 1'b1;
    redirect_pc = 32'h3001;
    step();
    redirect = 1'b0;
    sample();
    chk("mis_flag", 64'(fetch_misalign), 64'h1);
    chk("mis_cs", 64'(isram_cs), 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      sample();
      chk("mis_hold_cs", 64'(isram_cs), 64'h0);
      chk("mis_hold_valid", 64'(dec_valid), 64'h0);
    end
    step();
    redirect = 1'b1;
    redirect_pc = 32'h3000;
    push_exp(32'h3000, 32'h0020_0093, 1'b0);
    push_exp(32'h3004, 32'h0030_0093, 1'b0);
    step();
    redirect = 1'b0;
    sample();
    chk("unmis_flag", 64'(fetch_misalign), 64'h0);
    chk("unmis_cs", 64'(isram_cs), 64'h1);
    chk("unmis_adr", 64'(isram_adr), 64'h600);
    drain("misalign");

    // Reset with a nearly full queue and a response in flight
    step();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0000;
    dec_ready = 1'b0;
    step();
    redirect = 1'b0;
    step();
    step();
    step();
    sample();
    chk("mrst_pre_count", 64'(pfq_count), 64'h2);
    chk("mrst_pre_cs", 64'(isram_cs), 64'h1);
    step();
    cpurst = 1'b1;
    sample();
    chk("mrst_count", 64'(pfq_count), 64'h0);
    chk("mrst_cs", 64'(isram_cs), 64'h0);
    chk("mrst_valid", 64'(dec_valid), 64'h0);
    step();
    step();
    cpurst = 1'b0;
    dec_ready = 1'b1;
    push_boot_stream(4);
    sample();
    chk("mrst_boot_pc", 64'(fetch_pc), 64'h8000_0000);
    chk("mrst_boot_cs", 64'(isram_cs), 64'h1);
    chk("mrst_boot_adr", 64'(isram_adr), 64'h1000_0000);
    chk("mrst_boot_count", 64'(pfq_count), 64'h0);
    step();
    sample();
    chk("mrst_count_next", 64'(pfq_count), 64'h0);
    drain("reset_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
